// File: rtl/tpg_seq_ctrl.sv
// rtl/tpg_seq_ctrl.sv - LBIST pattern sequencer: seeded XNOR LFSR, bounded run, valid/ready handoff
module tpg_seq_ctrl #(
   parameter int               WIDTH     = 4,
   parameter int               CNT_W     = 16,
   parameter logic [WIDTH-1:0] SEED_DFLT = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             seed_load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic [CNT_W-1:0] pat_count_i,
   output logic [WIDTH-1:0] pat_o,
   output logic             pat_valid_o,
   input  logic             pat_ready_i,
   output logic             pat_last_o,
   output logic [CNT_W-1:0] pat_idx_o,
   output logic             busy_o,
   output logic             done_o
);

   generate
      if (WIDTH < 3 || WIDTH > 30) begin : g_bad_width
         $error("tpg_seq_ctrl: WIDTH must be in 3..30");
      end
   endgenerate

   // Tap positions use q-numbering (q[1] = MSB), so tap t lands on vector bit WIDTH-t.
   function automatic logic [WIDTH-1:0] tap_mask();
      logic [19:0]      t;
      logic [4:0]       tk;
      logic [WIDTH-1:0] m;
      case (WIDTH)
         3:  t = {5'd3,  5'd2,  5'd0,  5'd0};
         4:  t = {5'd4,  5'd3,  5'd0,  5'd0};
         5:  t = {5'd5,  5'd3,  5'd0,  5'd0};
         6:  t = {5'd6,  5'd5,  5'd0,  5'd0};
         7:  t = {5'd7,  5'd6,  5'd0,  5'd0};
         8:  t = {5'd8,  5'd6,  5'd5,  5'd4};
         9:  t = {5'd9,  5'd5,  5'd0,  5'd0};
         10: t = {5'd10, 5'd7,  5'd0,  5'd0};
         11: t = {5'd11, 5'd9,  5'd0,  5'd0};
         12: t = {5'd12, 5'd6,  5'd4,  5'd1};
         13: t = {5'd13, 5'd4,  5'd3,  5'd1};
         14: t = {5'd14, 5'd5,  5'd3,  5'd1};
         15: t = {5'd15, 5'd14, 5'd0,  5'd0};
         16: t = {5'd16, 5'd15, 5'd13, 5'd4};
         17: t = {5'd17, 5'd14, 5'd0,  5'd0};
         18: t = {5'd18, 5'd11, 5'd0,  5'd0};
         19: t = {5'd19, 5'd6,  5'd2,  5'd1};
         20: t = {5'd20, 5'd17, 5'd0,  5'd0};
         21: t = {5'd21, 5'd19, 5'd0,  5'd0};
         22: t = {5'd22, 5'd21, 5'd0,  5'd0};
         23: t = {5'd23, 5'd18, 5'd0,  5'd0};
         24: t = {5'd24, 5'd23, 5'd22, 5'd17};
         25: t = {5'd25, 5'd22, 5'd0,  5'd0};
         26: t = {5'd26, 5'd6,  5'd2,  5'd1};
         27: t = {5'd27, 5'd5,  5'd2,  5'd1};
         28: t = {5'd28, 5'd25, 5'd0,  5'd0};
         29: t = {5'd29, 5'd27, 5'd0,  5'd0};
         30: t = {5'd30, 5'd6,  5'd4,  5'd1};
         default: t = '0;
      endcase
      m = '0;
      for (int k = 0; k < 4; k++) begin
         tk = t[5*k +: 5];
         if (tk != 5'd0)
            m = m | (WIDTH'(1) << (WIDTH - int'(tk)));
      end
      return m;
   endfunction

   localparam logic [WIDTH-1:0] TAPS     = tap_mask();
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] idx_q;
   logic             accept;
   logic             last;
   logic             fb;

   assign last   = (state_q == RUN) && (idx_q == cnt_q - CNT_W'(1));
   assign accept = (state_q == RUN) && pat_ready_i && !abort_i;
   assign fb     = ~^(lfsr_q & TAPS);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_i) state_d = (pat_count_i != '0) ? RUN : DONE;
            RUN:     if (pat_ready_i && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      pat_valid_o = (state_q == RUN);
      busy_o      = (state_q == RUN);
      pat_last_o  = last;
      done_o      = (state_q == DONE);
      pat_o       = lfsr_q;
      pat_idx_o   = idx_q;
   end

   // A loaded all-ones seed would lock the XNOR LFSR, so it is swapped for the default.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= SEED_DFLT;
         cnt_q  <= '0;
         idx_q  <= '0;
      end else if (state_q == IDLE && start_i && !abort_i) begin
         cnt_q <= pat_count_i;
         idx_q <= '0;
         if (seed_load_i)
            lfsr_q <= (seed_i == ALL_ONES) ? SEED_DFLT : seed_i;
      end else if (accept) begin
         idx_q  <= idx_q + CNT_W'(1);
         lfsr_q <= {fb, lfsr_q[WIDTH-1:1]};
      end
   end

endmodule

// File: tb/tb_tpg_seq_ctrl.sv
// tb/tb_tpg_seq_ctrl.sv - directed self-checking bench for tpg_seq_ctrl (WIDTH=4)
module tb_tpg_seq_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start_i;
   logic        abort_i;
   logic        seed_load_i;
   logic [3:0]  seed_i;
   logic [15:0] pat_count_i;
   logic [3:0]  pat_o;
   logic        pat_valid_o;
   logic        pat_ready_i;
   logic        pat_last_o;
   logic [15:0] pat_idx_o;
   logic        busy_o;
   logic        done_o;

   int checks = 0;
   int errors = 0;

   // Hand-derived XNOR {4,3} sequence from state 1, period 15.
   logic [3:0] seq [15];

   tpg_seq_ctrl #(.WIDTH(4), .CNT_W(16), .SEED_DFLT(4'd1)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .seed_load_i (seed_load_i),
      .seed_i      (seed_i),
      .pat_count_i (pat_count_i),
      .pat_o       (pat_o),
      .pat_valid_o (pat_valid_o),
      .pat_ready_i (pat_ready_i),
      .pat_last_o  (pat_last_o),
      .pat_idx_o   (pat_idx_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic ld, input logic [3:0] sd, input logic [15:0] cnt);
      seed_load_i = ld;
      seed_i      = sd;
      pat_count_i = cnt;
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   task automatic check_pat(input string tag, input logic [3:0] p, input int idx, input logic lst);
      check({tag, "_valid"}, 32'(pat_valid_o), 32'd1);
      check({tag, "_pat"},   32'(pat_o),       32'(p));
      check({tag, "_idx"},   32'(pat_idx_o),   32'(idx));
      check({tag, "_last"},  32'(pat_last_o),  32'(lst));
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"},  32'(done_o),      32'd1);
      check({tag, "_dval"},  32'(pat_valid_o), 32'd0);
      tick();
      check({tag, "_done_clr"}, 32'(done_o),   32'd0);
      check({tag, "_idle"},  32'(busy_o),      32'd0);
   endtask

   initial begin
      seq = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE, 4'h7, 4'hB, 4'hD,
              4'h6, 4'h3, 4'h9, 4'h4, 4'hA, 4'h5, 4'h2};
      reset_n     = 1'b0;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      seed_load_i = 1'b0;
      seed_i      = 4'h0;
      pat_count_i = 16'd0;
      pat_ready_i = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(pat_valid_o), 32'd0);
      check("rst_busy",  32'(busy_o),      32'd0);
      check("rst_done",  32'(done_o),      32'd0);
      check("rst_last",  32'(pat_last_o),  32'd0);
      check("rst_pat",   32'(pat_o),       32'h1);
      check("rst_idx",   32'(pat_idx_o),   32'd0);
      reset_n = 1'b1;
      tick();

      // basic run of 7 from reset state
      start_run(1'b0, 4'h0, 16'd7);
      for (int i = 0; i < 7; i++) begin
         check_pat("run7", seq[i], i, i == 6);
         check("run7_busy", 32'(busy_o), 32'd1);
         tick();
      end
      check_done("run7");

      // full period: all-ones seed replaced by default, pattern 16 repeats pattern 1
      start_run(1'b1, 4'hF, 16'd16);
      for (int i = 0; i < 16; i++) begin
         check_pat("per16", seq[i % 15], i, i == 15);
         check("per16_notF", 32'(pat_o != 4'hF), 32'd1);
         tick();
      end
      check_done("per16");

      // backpressure at index 2, LFSR continues from seq[1]
      start_run(1'b0, 4'h0, 16'd5);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            pat_ready_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
               check_pat("bp_hold", seq[3], 2, 1'b0);
               tick();
            end
            pat_ready_i = 1'b1;
         end
         check_pat("bp", seq[1 + i], i, i == 4);
         tick();
      end
      check_done("bp");

      // seed 5 -> 5 then 2
      start_run(1'b1, 4'h5, 16'd2);
      check_pat("seed5_0", 4'h5, 0, 1'b0);
      tick();
      check_pat("seed5_1", 4'h2, 1, 1'b1);
      tick();
      check_done("seed5");

      // chaining: 1,0,8,C then continue E,7
      start_run(1'b1, 4'h1, 16'd4);
      for (int i = 0; i < 4; i++) begin
         check_pat("chainA", seq[i], i, i == 3);
         tick();
      end
      check_done("chainA");
      start_run(1'b0, 4'h9, 16'd2);
      for (int i = 0; i < 2; i++) begin
         check_pat("chainB", seq[4 + i], i, i == 1);
         tick();
      end
      check_done("chainB");

      // zero count: straight to done, never valid
      start_run(1'b1, 4'h1, 16'd0);
      check_done("zero");

      // abort at index 2: back to IDLE, LFSR not advanced, no done
      start_run(1'b1, 4'h1, 16'd6);
      tick();
      tick();
      check_pat("abort_pre", 4'h8, 2, 1'b0);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("abort_valid", 32'(pat_valid_o), 32'd0);
      check("abort_busy",  32'(busy_o),      32'd0);
      check("abort_done",  32'(done_o),      32'd0);
      check("abort_pat",   32'(pat_o),       32'h8);
      tick();
      check("abort_done2", 32'(done_o),      32'd0);

      // start while busy is ignored
      start_run(1'b1, 4'h1, 16'd4);
      pat_ready_i = 1'b0;
      start_run(1'b1, 4'h5, 16'd1);
      check_pat("ign", 4'h1, 0, 1'b0);
      pat_ready_i = 1'b1;
      tick();
      check_pat("ign_next", 4'h0, 1, 1'b0);

      // asynchronous reset mid-run, between clock edges
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(pat_valid_o), 32'd0);
      check("arst_busy",  32'(busy_o),      32'd0);
      check("arst_last",  32'(pat_last_o),  32'd0);
      check("arst_pat",   32'(pat_o),       32'h1);
      check("arst_idx",   32'(pat_idx_o),   32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      check("post_rst_valid", 32'(pat_valid_o), 32'd0);
      check("post_rst_done",  32'(done_o),      32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
